aq_ejpeg_rgb2ycbcr: RTL and testbench

Encoder-side colour front end, the mirror of the decoder's YCbCr-to-RGB stage. It accepts RGB pixels of one 16x16 MCU in MCU-raster order. It converts them to YCbCr, averages chroma 2x2 (4:2:0), and stores each MCU in one of two banks. It then emits 8x8 level-shifted blocks Y0,Y1,Y2,Y3,Cb,Cr to the forward DCT. Grayscale mode (JpegComp==1) emits Y0..Y3 only.

---
 rtl/aq_ejpeg_rgb2ycbcr.sv | 230 +++++++++++++++++++++++
 tb/tb_aq_ejpeg_rgb2ycbcr.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_ejpeg_rgb2ycbcr.sv
// rtl/aq_ejpeg_rgb2ycbcr.sv - RGB to YCbCr 4:2:0 MCU buffer feeding 8x8 level-shifted blocks to the forward DCT
module aq_ejpeg_rgb2ycbcr (
  input  logic       clk,
  input  logic       rst,
  input  logic       ProcessInit,
  input  logic [2:0] JpegComp,
  input  logic       InEnable,
  input  logic [7:0] InAddress,
  input  logic [7:0] InR,
  input  logic [7:0] InG,
  input  logic [7:0] InB,
  output logic       InFull,
  output logic       OutEnable,
  input  logic       OutReady,
  output logic [2:0] OutBlock,
  output logic [5:0] OutIndex,
  output logic [8:0] OutData
);

  // Bank bookkeeping: in_ptr follows accepted pixels (toggles on address 255),
  // rd_ptr follows transfers, iss_ptr follows samples loaded into the output register.
  logic [1:0] full;
  logic       in_ptr;
  logic       rd_ptr;
  logic       iss_ptr;

  logic       accept;
  logic [2:0] last_blk;

  assign InFull   = full[in_ptr];
  assign accept   = InEnable && !InFull && !ProcessInit;
  assign last_blk = (JpegComp == 3'd1) ? 3'd3 : 3'd5;

  // Stage 1 arithmetic on zero-extended inputs.
  logic signed [19:0] r_s, g_s, b_s;
  logic signed [19:0] y_sum, cb_sum, cr_sum;

  assign r_s    = $signed({12'd0, InR});
  assign g_s    = $signed({12'd0, InG});
  assign b_s    = $signed({12'd0, InB});
  assign y_sum  = 20'sd77 * r_s + 20'sd150 * g_s + 20'sd29 * b_s + 20'sd128;
  assign cb_sum = 20'sd128 * b_s - 20'sd43 * r_s - 20'sd85 * g_s + 20'sd128;
  assign cr_sum = 20'sd128 * r_s - 20'sd107 * g_s - 20'sd21 * b_s + 20'sd128;

  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    if (v < 20'sd0)
      return 8'd0;
    else if (v > 20'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

  logic               s1_valid, s2_valid;
  logic               s1_bank, s2_bank;
  logic [7:0]         s1_addr, s2_addr;
  logic signed [19:0] s1_y, s1_cb, s1_cr;
  logic [7:0]         s2_y, s2_cb, s2_cr;

  // Two-stage conversion pipeline: weighted sums, then shift/offset/clamp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_bank  <= 1'b0;
      s1_addr  <= 8'd0;
      s1_y     <= 20'sd0;
      s1_cb    <= 20'sd0;
      s1_cr    <= 20'sd0;
      s2_valid <= 1'b0;
      s2_bank  <= 1'b0;
      s2_addr  <= 8'd0;
      s2_y     <= 8'd0;
      s2_cb    <= 8'd0;
      s2_cr    <= 8'd0;
    end else if (ProcessInit) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_bank <= in_ptr;
        s1_addr <= InAddress;
        s1_y    <= y_sum;
        s1_cb   <= cb_sum;
        s1_cr   <= cr_sum;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bank <= s1_bank;
        s2_addr <= s1_addr;
        s2_y    <= clamp8(s1_y >>> 8);
        s2_cb   <= clamp8((s1_cb >>> 8) + 20'sd128);
        s2_cr   <= clamp8((s1_cr >>> 8) + 20'sd128);
      end
    end
  end

  // Storage: Y per pixel, chroma accumulators per 2x2 group (final average overwrites the partial).
  logic [7:0] y_mem  [0:511];
  logic [9:0] cb_mem [0:127];
  logic [9:0] cr_mem [0:127];

  logic       wr_en;
  logic [6:0] acc_wa;
  logic [7:0] cb_hold, cr_hold;
  logic [8:0] cb_pair, cr_pair;
  logic [9:0] cb_total, cr_total;

  assign wr_en    = s2_valid && !ProcessInit;
  assign acc_wa   = {s2_bank, s2_addr[7:5], s2_addr[3:1]};
  assign cb_pair  = {1'b0, cb_hold} + {1'b0, s2_cb};
  assign cr_pair  = {1'b0, cr_hold} + {1'b0, s2_cr};
  assign cb_total = cb_mem[acc_wa] + {1'b0, cb_pair} + 10'd2;
  assign cr_total = cr_mem[acc_wa] + {1'b0, cr_pair} + 10'd2;

  // Even-column chroma is held until its odd-column partner arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cb_hold <= 8'd0;
      cr_hold <= 8'd0;
    end else if (s2_valid && !s2_addr[0]) begin
      cb_hold <= s2_cb;
      cr_hold <= s2_cr;
    end
  end

  // Memory writes: even rows store the pair sum, odd rows complete the rounded average.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      y_mem[{s2_bank, s2_addr}] <= s2_y;
      if (s2_addr[0]) begin
        if (!s2_addr[4]) begin
          cb_mem[acc_wa] <= {1'b0, cb_pair};
          cr_mem[acc_wa] <= {1'b0, cr_pair};
        end else begin
          cb_mem[acc_wa] <= {2'b00, cb_total[9:2]};
          cr_mem[acc_wa] <= {2'b00, cr_total[9:2]};
        end
      end
    end
  end

  logic fill_done;
  logic xfer_last;

  assign fill_done = wr_en && (s2_addr == 8'hFF);
  assign xfer_last = OutEnable && OutReady && (OutBlock == last_blk) && (OutIndex == 6'd63);

  // Bank full flags and pointers; fill and free touch different banks so both may fire together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full   <= 2'b00;
      in_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (ProcessInit) begin
      full   <= 2'b00;
      in_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept && (InAddress == 8'hFF))
        in_ptr <= ~in_ptr;
      if (fill_done)
        full[s2_bank] <= 1'b1;
      if (xfer_last) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
    end
  end

  logic [2:0] cnt_blk;
  logic [5:0] cnt_idx;
  logic [9:0] sample;
  logic       load;
  logic       cnt_last;

  assign load     = (!OutEnable || OutReady) && full[iss_ptr];
  assign cnt_last = (cnt_blk == last_blk) && (cnt_idx == 6'd63);

  // Fetch the next sample of the issuing bank; Y blocks address a quadrant of the 16x16 MCU.
  always_comb begin
    sample = 10'd0;
    if (cnt_blk[2]) begin
      if (cnt_blk[0])
        sample = cr_mem[{iss_ptr, cnt_idx}];
      else
        sample = cb_mem[{iss_ptr, cnt_idx}];
    end else begin
      sample = {2'b00, y_mem[{iss_ptr, cnt_blk[1], cnt_idx[5:3], cnt_blk[0], cnt_idx[2:0]}]};
    end
  end

  // Output register: loads when empty or being consumed, otherwise holds under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      OutEnable <= 1'b0;
      OutBlock  <= 3'd0;
      OutIndex  <= 6'd0;
      OutData   <= 9'd0;
      cnt_blk   <= 3'd0;
      cnt_idx   <= 6'd0;
      iss_ptr   <= 1'b0;
    end else if (ProcessInit) begin
      OutEnable <= 1'b0;
      OutBlock  <= 3'd0;
      OutIndex  <= 6'd0;
      OutData   <= 9'd0;
      cnt_blk   <= 3'd0;
      cnt_idx   <= 6'd0;
      iss_ptr   <= 1'b0;
    end else if (load) begin
      OutEnable <= 1'b1;
      OutBlock  <= cnt_blk;
      OutIndex  <= cnt_idx;
      OutData   <= 9'(sample - 10'd128);
      if (cnt_last) begin
        cnt_blk <= 3'd0;
        cnt_idx <= 6'd0;
        iss_ptr <= ~iss_ptr;
      end else begin
        cnt_idx <= cnt_idx + 6'd1;
        if (cnt_idx == 6'd63)
          cnt_blk <= cnt_blk + 3'd1;
      end
    end else if (OutReady) begin
      OutEnable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aq_ejpeg_rgb2ycbcr.sv
// tb/tb_aq_ejpeg_rgb2ycbcr.sv - scoreboard bench for the RGB to YCbCr MCU front end
module tb_aq_ejpeg_rgb2ycbcr;

  logic       clk = 1'b0;
  logic       rst;
  logic       ProcessInit;
  logic [2:0] JpegComp;
  logic       InEnable;
  logic [7:0] InAddress, InR, InG, InB;
  logic       InFull;
  logic       OutEnable;
  logic       OutReady;
  logic [2:0] OutBlock;
  logic [5:0] OutIndex;
  logic [8:0] OutData;

  always #5 clk = ~clk;

  aq_ejpeg_rgb2ycbcr dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .JpegComp(JpegComp),
    .InEnable(InEnable), .InAddress(InAddress), .InR(InR), .InG(InG), .InB(InB),
    .InFull(InFull), .OutEnable(OutEnable), .OutReady(OutReady),
    .OutBlock(OutBlock), .OutIndex(OutIndex), .OutData(OutData)
  );

  typedef struct packed {
    logic [2:0] blk;
    logic [5:0] idx;
    logic [8:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests_run = 0;
  int   failed = 0;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every transfer is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst && OutEnable && OutReady) begin
      tests_run++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL extra_sample: got blk %0d idx %0d data %0d, expected no sample",
                 OutBlock, OutIndex, $signed(OutData));
      end else begin
        e = sb.pop_front();
        if (OutBlock !== e.blk || OutIndex !== e.idx || OutData !== e.data) begin
          failed++;
          $display("FAIL sample: got blk %0d idx %0d data %0d, expected blk %0d idx %0d data %0d",
                   OutBlock, OutIndex, $signed(OutData), e.blk, e.idx, $signed(e.data));
        end
      end
    end
  end

  // Pixel patterns: 0 mid-grey, 1 pure red, 2 red/black by column parity, 3 grey = address.
  function automatic logic [23:0] pix(input int mode, input int a);
    logic [7:0] v;
    v = 8'(a);
    case (mode)
      0: return {8'd128, 8'd128, 8'd128};
      1: return {8'd255, 8'd0, 8'd0};
      2: return (a % 2 == 0) ? {8'd255, 8'd0, 8'd0} : 24'd0;
      default: return {v, v, v};
    endcase
  endfunction

  // Hand-derived expected level-shifted samples per pattern.
  function automatic int exp_val(input int mode, input int blk, input int idx);
    int row, col;
    if (blk < 4) begin
      row = (blk / 2) * 8 + idx / 8;
      col = (blk % 2) * 8 + idx % 8;
      case (mode)
        0: return 0;
        1: return -51;
        2: return (col % 2 == 0) ? -51 : -128;
        default: return row * 16 + col - 128;
      endcase
    end else if (blk == 4) begin
      case (mode)
        1: return -43;
        2: return -21;
        default: return 0;
      endcase
    end else begin
      case (mode)
        1: return 127;
        2: return 64;
        default: return 0;
      endcase
    end
  endfunction

  task automatic push_expected(input int mode, input bit gray);
    int nblk;
    nblk = gray ? 4 : 6;
    for (int b = 0; b < nblk; b++)
      for (int i = 0; i < 64; i++)
        sb.push_back({3'(b), 6'(i), 9'(exp_val(mode, b, i))});
  endtask

  // Feed one MCU in address order; optional idle gaps; abort_at asserts ProcessInit with that pixel.
  task automatic feed_mcu(input int mode, input int gap_every, input int abort_at);
    int a;
    int guard;
    a = 0;
    guard = 0;
    while (a < 256) begin
      @(posedge clk); #1;
      InEnable = 1'b0;
      ProcessInit = 1'b0;
      guard++;
      if (guard > 5000) begin
        check("feed_timeout", a, 256);
        a = 256;
      end else if (a == abort_at) begin
        ProcessInit = 1'b1;
        InEnable = 1'b1;
        InAddress = 8'(a);
        {InR, InG, InB} = pix(mode, a);
        a = 256;
      end else if (InFull) begin
        InEnable = 1'b0;
      end else if (gap_every > 0 && (guard % gap_every) == 0) begin
        InEnable = 1'b0;
      end else begin
        InEnable = 1'b1;
        InAddress = 8'(a);
        {InR, InG, InB} = pix(mode, a);
        a++;
      end
    end
    @(posedge clk); #1;
    InEnable = 1'b0;
    ProcessInit = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  int  lat;
  int  bad;
  bit  seen;

  initial begin
    rst = 1'b0;
    ProcessInit = 1'b0;
    JpegComp = 3'd3;
    InEnable = 1'b0;
    InAddress = 8'd0;
    InR = 8'd0; InG = 8'd0; InB = 8'd0;
    OutReady = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_InFull", int'(InFull), 0);
    check("reset_OutEnable", int'(OutEnable), 0);
    check("reset_OutBlock", int'(OutBlock), 0);
    check("reset_OutIndex", int'(OutIndex), 0);
    check("reset_OutData", int'(OutData), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    OutReady = 1'b1;

    // 1: mid-grey with input gaps, plus first-sample latency
    push_expected(0, 1'b0);
    feed_mcu(0, 7, -1);
    lat = 0;
    while (!OutEnable && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("first_latency_le5", int'(lat <= 5), 1);
    wait_drain("drain_grey");

    // 2: saturated red, Cr clamps
    push_expected(1, 1'b0);
    feed_mcu(1, 0, -1);
    wait_drain("drain_red");

    // 3: alternating red/black columns, 2x2 averaging
    push_expected(2, 1'b0);
    feed_mcu(2, 0, -1);
    wait_drain("drain_alt");

    // 4: position map under intermittent backpressure
    push_expected(3, 1'b0);
    fork
      feed_mcu(3, 0, -1);
      begin
        for (int k = 0; k < 700; k++) begin
          @(posedge clk); #1;
          OutReady = (k % 3 != 0);
        end
        OutReady = 1'b1;
      end
    join
    wait_drain("drain_position");

    // 5: stalled sink over three MCUs
    @(posedge clk); #1;
    OutReady = 1'b0;
    push_expected(3, 1'b0);
    push_expected(1, 1'b0);
    push_expected(2, 1'b0);
    feed_mcu(3, 0, -1);
    feed_mcu(1, 0, -1);
    check("infull_two_banks", int'(InFull), 1);
    repeat (5) @(posedge clk);
    #1;
    check("hold_enable", int'(OutEnable), 1);
    check("hold_block", int'(OutBlock), 0);
    check("hold_index", int'(OutIndex), 0);
    check("hold_data", int'($signed(OutData)), -128);
    seen = 1'b0;
    fork
      feed_mcu(2, 0, -1);
      begin
        OutReady = 1'b1;
        for (int k = 0; k < 2000 && !seen; k++) begin
          @(negedge clk);
          if (OutEnable && OutReady && OutBlock == 3'd5 && OutIndex == 6'd63) begin
            seen = 1'b1;
            check("infull_before_free", int'(InFull), 1);
            @(negedge clk);
            check("infull_after_free", int'(InFull), 0);
          end
        end
        check("first_bank_freed", int'(seen), 1);
      end
    join
    wait_drain("drain_stalled");

    // 6: grayscale, then ProcessInit mid-MCU
    JpegComp = 3'd1;
    push_expected(3, 1'b1);
    feed_mcu(3, 0, -1);
    wait_drain("drain_gray_pos");
    feed_mcu(0, 0, 100);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (OutEnable || InFull)
        bad++;
    end
    check("abort_quiet_cycles", bad, 0);
    push_expected(2, 1'b1);
    feed_mcu(2, 0, -1);
    wait_drain("drain_gray_after_abort");

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
